// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor that processes CHUNK bits per
// clock. A request captures the operands, the RUN state walks the chunks from
// LSB to MSB through one CHUNK-bit adder, and the final edge publishes sum,
// carry-out and signed overflow together with a one-cycle done pulse.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; busy=0, done=0
// S_RUN  | one chunk added per edge; busy=1, start ignored
// S_DONE | results valid this cycle; done=1, start here chains a new op
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (CHUNK < 1 || WIDTH < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("chunked_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_eff_q;   // b already inverted for subtraction
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_d;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK-1:0] s_slice;
  logic             c_next;
  logic             c_into_msb;
  int               base;

  // Chunk adder on the slice selected by the counter, plus shadow merge.
  always_comb begin
    base       = int'(cnt_q) * CHUNK;
    a_slice    = a_q[base +: CHUNK];
    b_slice    = b_eff_q[base +: CHUNK];
    {c_next, s_slice} = {1'b0, a_slice} + {1'b0, b_slice}
                      + {{CHUNK{1'b0}}, carry_q};
    // Only meaningful on the top chunk: recover the carry into bit WIDTH-1
    // from the sum bit and its two operand bits.
    c_into_msb = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ s_slice[CHUNK-1];
    shadow_d   = shadow_q;
    shadow_d[base +: CHUNK] = s_slice;
  end

  // Sequencer with registered status and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_eff_q  <= '0;
      shadow_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_eff_q  <= sub ? ~b : b;
            carry_q  <= sub ? 1'b1 : cin;
            cnt_q    <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          shadow_q <= shadow_d;
          carry_q  <= c_next;
          if (cnt_q == LAST) begin
            sum_q   <= shadow_d;
            cout_q  <= c_next;
            ovf_q   <= c_into_msb ^ c_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule
